// File: rtl/online_digit_select.sv
// Radix-2 online-multiplier selection stage: digit selection and residual update from a carry-save residual.
// Optional estimate-overflow flag enabled by defining ONLINE_SEL_OVF_CHECK_EN (otherwise ovf is tied low).
module online_digit_select #(
    parameter int FRAC  = 16,
    parameter int NDIG  = 16,
    parameter int DELTA = 3,
    localparam int W    = FRAC + 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_wc,
    input  logic [W-1:0] in_ws,
    output logic [W-1:0] res_wc,
    output logic [W-1:0] res_ws,
    output logic         res_valid,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         zp,
    output logic         zn,
    output logic         busy,
    output logic         done,
    output logic         ovf,
    output logic [1:0]   dbg_state
);
    typedef enum logic [1:0] {IDLE, INIT, RUN, DRAIN} state_t;

    localparam logic [8:0]   CNT_INIT = 9'(DELTA);
    localparam logic [8:0]   CNT_LAST = 9'(DELTA + NDIG);
    localparam logic [W-1:0] ONE      = {2'b00, 1'b1, {FRAC{1'b0}}};

    state_t             state_q, state_d;
    logic [8:0]         cnt_q, cnt_inc;
    logic               accept, take;
    logic signed [4:0]  est;
    logic               sel_pos, sel_neg;
    logic [W-1:0]       ws_adj, res_ws_d, res_wc_d;

    // Handshakes: a beat/digit transfers on the rising edge where valid && ready are both high;
    // valid never depends on ready, and in_ready only depends on state and the digit slot.
    assign accept  = in_valid && in_ready;
    assign take    = out_valid && out_ready;
    assign cnt_inc = cnt_q + 9'd1;

    // Top five bits of each vector sum to the residual estimate in units of 1/4.
    assign est      = signed'(in_ws[W-1:FRAC-2]) + signed'(in_wc[W-1:FRAC-2]);
    assign sel_pos  = (state_q == RUN) && (est >= 5'sd2);
    assign sel_neg  = (state_q == RUN) && (est <= -5'sd3);
    assign ws_adj   = in_ws - (sel_pos ? ONE : '0) + (sel_neg ? ONE : '0);
    assign res_ws_d = ws_adj << 1;
    assign res_wc_d = in_wc << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (DELTA == 0) ? RUN : INIT;
            INIT:    if (accept && cnt_inc == CNT_INIT) state_d = RUN;
            RUN:     if (accept && cnt_inc == CNT_LAST) state_d = DRAIN;
            DRAIN:   if (take) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == INIT) || ((state_q == RUN) && (!out_valid || out_ready));
        busy      = (state_q != IDLE);
        dbg_state = state_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            res_wc    <= '0;
            res_ws    <= '0;
            res_valid <= 1'b0;
            out_valid <= 1'b0;
            zp        <= 1'b0;
            zn        <= 1'b0;
            done      <= 1'b0;
        end else begin
            res_valid <= accept;
            done      <= (state_q == DRAIN) && take;
            if (state_q == IDLE && start) cnt_q <= '0;
            else if (accept)              cnt_q <= cnt_inc;
            if (accept) begin
                res_ws <= res_ws_d;
                res_wc <= res_wc_d;
            end
            // A load in the same cycle as a take replaces the digit and keeps the slot full.
            if (accept && state_q == RUN) begin
                out_valid <= 1'b1;
                zp        <= sel_pos;
                zn        <= sel_neg;
            end else if (take) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef ONLINE_SEL_OVF_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                     ovf <= 1'b0;
        else if (state_q == IDLE && start)              ovf <= 1'b0;
        else if (accept && (est >= 5'sd6 || est <= -5'sd7)) ovf <= 1'b1;
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_online_digit_select.sv
// Directed bench for online_digit_select: scoreboard of expected residuals/digits checked by a negedge monitor.
module tb_online_digit_select;
    localparam int FRAC  = 16;
    localparam int NDIG  = 4;
    localparam int DELTA = 3;
    localparam int W     = FRAC + 3;
`ifdef ONLINE_SEL_OVF_CHECK_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n, start, in_valid, out_ready;
    logic [W-1:0] in_wc, in_ws;
    logic         in_ready, res_valid, out_valid, zp, zn, busy, done, ovf;
    logic [W-1:0] res_wc, res_ws;
    logic [1:0]   dbg_state;

    online_digit_select #(.FRAC(FRAC), .NDIG(NDIG), .DELTA(DELTA)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_wc(in_wc), .in_ws(in_ws), .res_wc(res_wc), .res_ws(res_ws), .res_valid(res_valid),
        .out_valid(out_valid), .out_ready(out_ready), .zp(zp), .zn(zn), .busy(busy),
        .done(done), .ovf(ovf), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int bn     = 0;
    int rv_cnt = 0;
    logic [2*W-1:0] exp_res_q[$];
    logic [2:0]     exp_dig_q[$];
    logic           done_pend = 1'b0;
    logic [2*W-1:0] mon_e;
    logic [2:0]     mon_d;
    logic [W-1:0]   held_ws, held_wc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: estimate, selection and residual update from the block's arithmetic definition.
    function automatic logic [2*W+1:0] model(input logic [W-1:0] ws, input logic [W-1:0] wc, input bit run);
        logic signed [4:0] a, b;
        logic [W-1:0]      pf, r;
        int v, p;
        a = ws[W-1:W-5];
        b = wc[W-1:W-5];
        v = int'(a) + int'(b);
        if (v > 15) v -= 32;
        else if (v < -16) v += 32;
        p = !run ? 0 : (v >= 2 ? 1 : (v <= -3 ? -1 : 0));
        pf = W'(p * (1 << FRAC));
        r  = ws - pf;
        return {p == 1, p == -1, r << 1, wc << 1};
    endfunction

    function automatic logic [W-1:0] rnd_res();
        logic [W-1:0] r;
        logic [4:0]   t;
        r = W'($urandom_range(0, (1 << W) - 1));
        t = 5'($urandom_range(0, 3)) - 5'd2;
        r[W-1:W-5] = t;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            done_pend = 1'b0;
        end else begin
            chk("done", done, done_pend);
            done_pend = 1'b0;
            if (res_valid) begin
                rv_cnt++;
                chk("res_expected_present", exp_res_q.size() > 0, 1);
                if (exp_res_q.size() > 0) begin
                    mon_e = exp_res_q.pop_front();
                    chk("res_ws", res_ws, mon_e[2*W-1:W]);
                    chk("res_wc", res_wc, mon_e[W-1:0]);
                end
            end
            if (out_valid && out_ready) begin
                chk("digit_expected_present", exp_dig_q.size() > 0, 1);
                if (exp_dig_q.size() > 0) begin
                    mon_d = exp_dig_q.pop_front();
                    chk("digit", {zp, zn}, mon_d[1:0]);
                    done_pend = mon_d[2];
                end
            end
        end
    end

    task automatic send_raw(input logic [W-1:0] ws, input logic [W-1:0] wc,
                            input logic [W-1:0] ers, input logic [W-1:0] erc, input logic [1:0] edig);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_ws    = ws;
        in_wc    = wc;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_res_q.push_back({ers, erc});
                if (bn >= DELTA) exp_dig_q.push_back({bn == DELTA + NDIG - 1, edig});
                ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        bn++;
        chk("beat_accept_timeout", ok, 1);
    endtask

    task automatic beat(input logic [W-1:0] ws, input logic [W-1:0] wc);
        logic [2*W+1:0] m;
        m = model(ws, wc, bn >= DELTA);
        send_raw(ws, wc, m[2*W-1:W], m[W-1:0], m[2*W+1:2*W]);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        bn     = 0;
        rv_cnt = 0;
    endtask

    task automatic finish_op();
        bit idle = 1'b0;
        for (int k = 0; k < 100 && !idle; k++) begin
            @(negedge clk);
            if (!busy) idle = 1'b1;
        end
        chk("op_end_timeout", idle, 1);
        chk("res_valid_count", rv_cnt, DELTA + NDIG);
        chk("res_queue_empty", exp_res_q.size(), 0);
        chk("digit_queue_empty", exp_dig_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_res_wc"}, res_wc, 0);
        chk({tag, "_res_ws"}, res_ws, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_digit"}, {zp, zn}, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_ovf"}, ovf, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_state"}, dbg_state, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_ws = '0; in_wc = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_values("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero residual: DELTA silent beats, then NDIG zero digits.
        do_start();
        chk("busy_after_start", busy, 1);
        chk("no_digit_after_start", out_valid, 0);
        for (int i = 0; i < DELTA + NDIG; i++) send_raw('0, '0, '0, '0, 2'b00);
        finish_op();

        // Directed estimates: INIT forces p=0, then selection boundaries in RUN.
        do_start();
        send_raw(19'h10000, 19'h00000, 19'h20000, 19'h00000, 2'b00);
        send_raw(19'h74000, 19'h00000, 19'h68000, 19'h00000, 2'b00);
        send_raw(19'h00000, 19'h10000, 19'h00000, 19'h20000, 2'b00);
        send_raw(19'h10000, 19'h00000, 19'h00000, 19'h00000, 2'b10);
        send_raw(19'h74000, 19'h00000, 19'h08000, 19'h00000, 2'b01);
        send_raw(19'h78000, 19'h00000, 19'h70000, 19'h00000, 2'b00);
        send_raw(19'h08000, 19'h04000, 19'h70000, 19'h08000, 2'b10);
        finish_op();
        chk("ovf_quiet", ovf, 0);

        // Backpressure: held digit blocks input, residual holds, stream resumes intact.
        out_ready = 1'b0;
        do_start();
        for (int i = 0; i < DELTA + 1; i++) beat(rnd_res(), rnd_res());
        held_ws  = res_ws;
        held_wc  = res_wc;
        in_valid = 1'b1;
        in_ws    = rnd_res();
        in_wc    = rnd_res();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_res_ws", res_ws, held_ws);
            chk("bp_res_wc", res_wc, held_wc);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < NDIG - 1; i++) beat(rnd_res(), rnd_res());
        finish_op();

        // Estimate overflow flag.
        do_start();
        for (int i = 0; i < DELTA; i++) beat(rnd_res(), rnd_res());
        chk("ovf_before", ovf, 0);
        send_raw(19'h18000, 19'h00000, 19'h10000, 19'h00000, 2'b10);
        chk("ovf_set", ovf, OVF_EXP);
        for (int i = 0; i < NDIG - 1; i++) beat(rnd_res(), rnd_res());
        finish_op();
        chk("ovf_sticky", ovf, OVF_EXP);

        // Next start clears ovf; reset mid-RUN returns everything at once.
        do_start();
        chk("ovf_cleared_by_start", ovf, 0);
        for (int i = 0; i < DELTA + 2; i++) beat(rnd_res(), rnd_res());
        chk("mid_run_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_values("async_reset");
        exp_res_q.delete();
        exp_dig_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Normal operation after reset; a start pulse while busy is ignored.
        do_start();
        for (int i = 0; i < DELTA; i++) beat(rnd_res(), rnd_res());
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < NDIG; i++) beat(rnd_res(), rnd_res());
        finish_op();
        chk("idle_state", dbg_state, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
